// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one small ALU between several requesters
//
// Purpose:
//   Grants one pending requester at a time (round-robin), captures its op code
//   and operands, computes a W+1-bit ALU result and returns it with the
//   requester index over a valid/ready handshake.
//   Op codes: 00 AND, 01 OR, 10 SUB (wraps to W+1 bits), 11 ADD (carry in bit W).
//
// Optional feature:
//   ALU_SHARE_ARB_PIPE_EN - adds an EXEC2 state; the raw ALU result is
//   registered in EXEC and moved to rsp_data in EXEC2 (one extra cycle).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held high until granted
//   req_code   op code per requester, slice i = [2i+1:2i]
//   req_a      operand a per requester, slice i = [W*i+W-1:W*i]
//   req_b      operand b per requester, same slicing
//   gnt        one-hot, one-cycle pulse: request i accepted
//   rsp_valid  result available
//   rsp_id     index of the requester owning the result
//   rsp_data   ALU result (W+1 bits)
//   rsp_ready  consumer accepts the result
//   busy       high whenever the FSM is not idle

module alu_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_code,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W:0]          rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);

`ifdef ALU_SHARE_ARB_PIPE_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_EXEC2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
`endif

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [1:0]     code_q, code_n;
    logic [W-1:0]   a_q, a_n;
    logic [W-1:0]   b_q, b_n;
    logic [IDW-1:0] sel_q, sel_n;
    logic [NREQ-1:0] gnt_n;
    logic           valid_n;
    logic [IDW-1:0] id_n;
    logic [W:0]     data_n;
    logic           busy_n;
    logic [IDW-1:0] sel_c;
    logic [IDW-1:0] cand;
`ifdef ALU_SHARE_ARB_PIPE_EN
    logic [W:0]     res_q, res_n;
`endif

    function automatic logic [W:0] alu(input logic [1:0] code,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        logic [W:0] r;
        case (code)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a} - {1'b0, b};
            default: r = {1'b0, a} + {1'b0, b};
        endcase
        return r;
    endfunction

    // Round-robin pick: scan downward from ptr+NREQ to ptr+1 so the last hit,
    // i.e. the closest index above ptr, wins. Indices never reach NREQ.
    always_comb begin
        sel_c = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                sel_c = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        code_n  = code_q;
        a_n     = a_q;
        b_n     = b_q;
        sel_n   = sel_q;
        gnt_n   = '0;
        valid_n = rsp_valid;
        id_n    = rsp_id;
        data_n  = rsp_data;
`ifdef ALU_SHARE_ARB_PIPE_EN
        res_n   = res_q;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    gnt_n   = NREQ'(1) << sel_c;
                    code_n  = req_code[2*sel_c +: 2];
                    a_n     = req_a[W*sel_c +: W];
                    b_n     = req_b[W*sel_c +: W];
                    sel_n   = sel_c;
                    ptr_n   = sel_c;
                    state_n = S_EXEC;
                end
            end
`ifdef ALU_SHARE_ARB_PIPE_EN
            S_EXEC: begin
                res_n   = alu(code_q, a_q, b_q);
                state_n = S_EXEC2;
            end
            S_EXEC2: begin
                data_n  = res_q;
                id_n    = sel_q;
                valid_n = 1'b1;
                state_n = S_RESP;
            end
`else
            S_EXEC: begin
                data_n  = alu(code_q, a_q, b_q);
                id_n    = sel_q;
                valid_n = 1'b1;
                state_n = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
        // busy is registered, so it follows the state being entered
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= IDW'(NREQ - 1);
            code_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef ALU_SHARE_ARB_PIPE_EN
            res_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            code_q    <= code_n;
            a_q       <= a_n;
            b_q       <= b_n;
            sel_q     <= sel_n;
            gnt       <= gnt_n;
            rsp_valid <= valid_n;
            rsp_id    <= id_n;
            rsp_data  <= data_n;
            busy      <= busy_n;
`ifdef ALU_SHARE_ARB_PIPE_EN
            res_q     <= res_n;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb
module tb_alu_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 4;
`ifdef ALU_SHARE_ARB_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_code;
    logic [W*NREQ-1:0]   req_a;
    logic [W*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [W:0]          rsp_data;
    logic                rsp_ready;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    int ptr_m;
    int order_q[$];

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_code  (req_code),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_alu(input int code, input int a, input int b);
        int mask;
        mask = (1 << (W + 1)) - 1;
        case (code)
            0:       return a & b;
            1:       return a | b;
            2:       return (a - b) & mask;
            default: return (a + b) & mask;
        endcase
    endfunction

    // First asserted requester after the last one served, wrapping around.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic run_job(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] c,
                           input logic [W*NREQ-1:0] a, input logic [W*NREQ-1:0] b,
                           input bit hold, input int delay, input string tag);
        int sel;
        int expd;
        sel  = pick(r);
        expd = ref_alu(int'(c[2*sel +: 2]), int'(a[W*sel +: W]), int'(b[W*sel +: W]));
        ptr_m = sel;
        order_q.push_back(sel);
        req = r; req_code = c; req_a = a; req_b = b; rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".gnt"}, 32'(gnt), 32'(1 << sel));
        check({tag, ".busy_exec"}, 32'(busy), 32'd1);
        check({tag, ".valid_early"}, 32'(rsp_valid), 32'd0);
        if (!hold) req = '0;
        req_code = 8'($urandom);
        req_a    = 16'($urandom);
        req_b    = 16'($urandom);
        for (int p = 0; p < PIPE; p++) begin
            @(negedge clk);
            check({tag, ".valid_pipe"}, 32'(rsp_valid), 32'd0);
            check({tag, ".gnt_pipe"}, 32'(gnt), 32'd0);
        end
        @(negedge clk);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".data"}, 32'(rsp_data), 32'(expd));
        check({tag, ".id"}, 32'(rsp_id), 32'(sel));
        check({tag, ".gnt_busy"}, 32'(gnt), 32'd0);
        for (int d = 0; d < delay; d++) begin
            if (!hold) req = 4'($urandom);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_data"}, 32'(rsp_data), 32'(expd));
            check({tag, ".hold_id"}, 32'(rsp_id), 32'(sel));
            check({tag, ".hold_gnt"}, 32'(gnt), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        if (!hold) req = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".busy_drop"}, 32'(busy), 32'd0);
        check({tag, ".gnt_drop"}, 32'(gnt), 32'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
    endtask

    initial begin
        logic [2*NREQ-1:0] c;
        logic [W*NREQ-1:0] a, b;
        logic [NREQ-1:0]   r;
        int exp_order[5];
        int got;

        // reset with arbitrary inputs
        rst_n = 1'b0;
        req = 4'($urandom); req_code = 8'($urandom);
        req_a = 16'($urandom); req_b = 16'($urandom); rsp_ready = 1'($urandom);
        repeat (2) @(negedge clk);
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.id", 32'(rsp_id), 32'd0);
        check("rst.data", 32'(rsp_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        req = '0; rsp_ready = 1'b0;
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
        @(negedge clk);

        // first job: 9 + 8 on requester 0
        c = '0; a = '0; b = '0;
        c[1:0] = 2'b11; a[3:0] = 4'd9; b[3:0] = 4'd8;
        run_job(4'b0001, c, a, b, 1'b0, 0, "first");

        // op sweep on requester 2
        c = '0; a = '0; b = '0;
        c[5:4] = 2'b00; a[11:8] = 4'hC; b[11:8] = 4'hA;
        run_job(4'b0100, c, a, b, 1'b0, 0, "op_and");
        c[5:4] = 2'b01;
        run_job(4'b0100, c, a, b, 1'b0, 0, "op_or");
        c[5:4] = 2'b10; a[11:8] = 4'd3; b[11:8] = 4'd5;
        run_job(4'b0100, c, a, b, 1'b0, 0, "op_sub");
        c[5:4] = 2'b11; a[11:8] = 4'hF; b[11:8] = 4'hF;
        run_job(4'b0100, c, a, b, 1'b0, 0, "op_add");

        // backpressure: five cycles without ready, operands scrambled after gnt
        c = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
        run_job(4'b1000, c, a, b, 1'b0, 5, "bp");

        // reset while in EXEC
        c = '0; a = '0; b = '0;
        c[5:4] = 2'b11; a[11:8] = 4'd7; b[11:8] = 4'd1;
        req = 4'b0100; req_code = c; req_a = a; req_b = b; rsp_ready = 1'b1;
        @(negedge clk);
        check("midrst.gnt", 32'(gnt), 32'b0100);
        rst_n = 1'b0;
        req = '0;
        #1;
        check("midrst.valid", 32'(rsp_valid), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst.valid_low", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        ptr_m = NREQ - 1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("midrst.idle_gnt", 32'(gnt), 32'd0);
        check("midrst.idle_valid", 32'(rsp_valid), 32'd0);
        c = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
        run_job(4'b0010, c, a, b, 1'b0, 1, "after_rst");

        // round robin with all requests held
        do_reset();
        @(negedge clk);
        order_q.delete();
        exp_order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            c = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
            run_job(4'b1111, c, a, b, 1'b1, 0, "rr");
        end
        for (int j = 0; j < 5; j++) begin
            got = order_q[j];
            check("rr.order", 32'(got), 32'(exp_order[j]));
        end
        req = '0;
        @(negedge clk);
        check("rr.idle_gnt", 32'(gnt), 32'd0);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            r = 4'($urandom);
            if (r == '0) r[$urandom_range(NREQ - 1, 0)] = 1'b1;
            c = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
            run_job(r, c, a, b, 1'($urandom), $urandom_range(3, 0), "rnd");
        end
        req = '0;
        repeat (2) @(negedge clk);
        check("end.gnt", 32'(gnt), 32'd0);
        check("end.busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
